sub_accum: RTL and testbench
============================

# sub_accum

- Block-level consumer for the `sub` output pair: signed 4-bit `as` and unsigned 4-bit `bs`.
- Accepts one `as`/`bs` sample per valid/ready handshake and accumulates BLOCK_LEN samples.
  - `as` is sign-extended; `bs` is zero-extended.
- Presents both sums on a registered valid/ready output port.
- Sits directly downstream of `sub` and is the receiving end of its interface; its job is to keep the signed/unsigned distinction correct through widening.

## Interface
- ACC_W, 12: accumulator and output width; legal range 5..32.
- BLOCK_LEN, 8: samples per result; legal range 1..255.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  `as`/`bs` sample present.
- in_ready  out  1  block can accept a sample.
- as  in  signed [3:0]  signed sample.
- bs  in  [3:0]  unsigned sample.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum_as  out  signed [ACC_W-1:0]  signed sum of `as`.
- sum_bs  out  [ACC_W-1:0]  unsigned sum of `bs`.
- ovf  out  1  saturation occurred in this block (see Configuration).

## Operation
- States:
  - IDLE: no samples taken.
  - ACCUM: 1..BLOCK_LEN-1 samples taken.
  - HOLD: result presented.
- Reset values: state=IDLE, count=0, sum_as=0, sum_bs=0, ovf=0, out_valid=0.
- in_ready is 1 in IDLE and ACCUM and 0 in HOLD; it is decoded from the registered state.
- Accept = in_valid && in_ready. Cycles without an accept change nothing.
- On accept, both sums update and count increments:
  - sum_as += sign-extended `as`.
  - sum_bs += zero-extended `bs`.
- IDLE transitions on accept:
  - count becomes 1.
  - Next state is ACCUM, or HOLD if BLOCK_LEN==1.
- ACCUM transitions on accept:
  - If count+1 == BLOCK_LEN, go to HOLD.
  - Otherwise stay in ACCUM.
- HOLD behaviour:
  - out_valid=1.
  - sum_as, sum_bs and ovf are held stable until out_ready.
  - in_valid is ignored.
- HOLD exit on out_valid && out_ready:
  - Go to IDLE.
  - Clear sums, count and ovf to 0.
- Width rules:
  - Sign extension replicates as[3].
  - Addition is ACC_W-bit two's-complement for sum_as and unsigned for sum_bs.
- Reset while in ACCUM or HOLD discards the partial or pending result and returns to the reset values.

## Timing
- Sums and count update on the same edge as the accept.
- out_valid rises on the edge of the BLOCK_LEN-th accept, i.e. it is visible the cycle after that sample is presented.
- Result handoff: the cycle after the out_ready handshake, out_valid=0 and in_ready=1.
- Throughput: BLOCK_LEN accepts, then at least 1 HOLD cycle, per result.
- No combinational path from any input to any output. in_ready depends on state only.

## Configuration
- Macro: SUB_ACCUM_SAT_EN.
- Defined:
  - Each add saturates: sum_as clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1], sum_bs clamps to 2^ACC_W-1.
  - ovf is set sticky when any clamp occurs and cleared on result handoff or reset.
- Undefined:
  - Adds wrap modulo 2^ACC_W.
  - ovf is tied to 0.

## Structure
- sub_accum_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - SAMPLE_W=4;
  - the count-width function ($clog2(BLOCK_LEN+1)).
- One sub-module, sub_accum_add, parameterised by width and signedness:
  - performs the extend-add, plus the saturation and overflow flag under SUB_ACCUM_SAT_EN;
  - instantiated twice (signed for `as`, unsigned for `bs`).

## Test plan
- Reset: rst_n=0 for 2 cycles mid-stream.
  - Next cycle: out_valid=0, in_ready=1, sum_as=0, sum_bs=0, ovf=0.
- Extension check (defaults): 8 accepts with as=4'b1111 and bs=4'b1111.
  - sum_as=-8 (12'hFF8), sum_bs=120 (12'h078).
  - out_valid=1 the cycle after the 8th accept.
- Extremes (defaults): 8 accepts with as=-8, bs=0.
  - sum_as=-64 (12'hFC0), sum_bs=0.
  - Then 8 accepts with as=7, bs=15: sum_as=56, sum_bs=120.
- Backpressure and gaps:
  - Random in_valid gaps give the same sums as the contiguous case.
  - In HOLD with out_ready=0 for 5 cycles and in_valid=1: outputs stable, in_ready=0, no sample absorbed.
- Overflow with ACC_W=6, BLOCK_LEN=8, 8 accepts of as=7, bs=15:
  - With SUB_ACCUM_SAT_EN: sum_as=31, sum_bs=63, ovf=1.
  - Without SUB_ACCUM_SAT_EN: sum_as=-8, sum_bs=56, ovf=0.
- Reset mid-operation: 3 accepts, then rst_n=0 for 1 cycle, then 8 accepts of as=1, bs=1.
  - sum_as=8, sum_bs=8; no residue from the first 3 samples.

Source files
------------

// File: rtl/sub_accum_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sub_accum_pkg : shared types, sample width and counter sizing for sub_accum
// | Revision      : 1.0
// +-----------------------------------------------------------------------------
package sub_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int SAMPLE_W = 4;

   function automatic int count_w(input int block_len);
      return $clog2(block_len + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sub_accum_add.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sub_accum_add : widen one 4-bit sample (sign- or zero-extend) and add it to
// |                 the accumulator; clamps and flags overflow under SUB_ACCUM_SAT_EN
// | Revision      : 1.0
// +-----------------------------------------------------------------------------
module sub_accum_add
   import sub_accum_pkg::*;
#(
   parameter int ACC_W     = 12,
   parameter bit IS_SIGNED = 1'b1
) (
   input  logic [ACC_W-1:0]    acc,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [ACC_W-1:0]    sum,
   output logic                clamp
);

   logic [ACC_W-1:0] ext;

   generate
      if (IS_SIGNED) begin : g_sext
         assign ext = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
      end else begin : g_zext
         assign ext = {{(ACC_W-SAMPLE_W){1'b0}}, sample};
      end
   endgenerate

`ifdef SUB_ACCUM_SAT_EN
   logic [ACC_W:0] wide;

   generate
      if (IS_SIGNED) begin : g_sat_s
         // One guard bit: disagreement with the MSB means the true sign (bit ACC_W) was lost.
         assign wide  = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
         assign clamp = wide[ACC_W] ^ wide[ACC_W-1];
         assign sum   = !clamp      ? wide[ACC_W-1:0] :
                        wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};
      end else begin : g_sat_u
         assign wide  = {1'b0, acc} + {1'b0, ext};
         assign clamp = wide[ACC_W];
         assign sum   = clamp ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
      end
   endgenerate
`else
   assign sum   = acc + ext;
   assign clamp = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/sub_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sub_accum : accumulates BLOCK_LEN signed/unsigned sample pairs and presents
// |             both sums on a registered valid/ready port (option: SUB_ACCUM_SAT_EN)
// | Revision  : 1.0
// +-----------------------------------------------------------------------------
module sub_accum
   import sub_accum_pkg::*;
#(
   parameter int ACC_W     = 12,
   parameter int BLOCK_LEN = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [3:0]       as,
   input  logic [3:0]              bs,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] sum_as,
   output logic [ACC_W-1:0]        sum_bs,
   output logic                    ovf
);

   localparam int               CNT_W    = count_w(BLOCK_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic signed [ACC_W-1:0]   sum_as_q, sum_as_d;
   logic [ACC_W-1:0]          sum_bs_q, sum_bs_d;
   logic                      ovf_q, ovf_d;
   logic                      out_valid_q, out_valid_d;

   logic [ACC_W-1:0]          add_as, add_bs;
   logic                      clamp_as, clamp_bs;
   logic                      accept;

   sub_accum_add #(.ACC_W(ACC_W), .IS_SIGNED(1'b1)) u_add_as (
      .acc    (sum_as_q),
      .sample (as),
      .sum    (add_as),
      .clamp  (clamp_as)
   );

   sub_accum_add #(.ACC_W(ACC_W), .IS_SIGNED(1'b0)) u_add_bs (
      .acc    (sum_bs_q),
      .sample (bs),
      .sum    (add_bs),
      .clamp  (clamp_bs)
   );

   assign in_ready = (state_q != HOLD);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      sum_as_d    = sum_as_q;
      sum_bs_d    = sum_bs_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE, ACCUM: begin
            // IDLE has count 0, so a single compare also covers BLOCK_LEN == 1.
            if (accept) begin
               sum_as_d = add_as;
               sum_bs_d = add_bs;
               ovf_d    = ovf_q | clamp_as | clamp_bs;
               count_d  = count_q + 1'b1;
               if (count_q == LAST_CNT) begin
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d     = IDLE;
               count_d     = '0;
               sum_as_d    = '0;
               sum_bs_d    = '0;
               ovf_d       = 1'b0;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            count_d     = '0;
            sum_as_d    = '0;
            sum_bs_d    = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         sum_as_q    <= '0;
         sum_bs_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sum_as_q    <= sum_as_d;
         sum_bs_q    <= sum_bs_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum_as    = sum_as_q;
   assign sum_bs    = sum_bs_q;
   assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_sub_accum : randomized bench for sub_accum; a 12-bit and a 6-bit instance
// |                run in lockstep against an integer reference model
// | Revision     : 1.0
// +-----------------------------------------------------------------------------
module tb_sub_accum;

   localparam int BL = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              out_ready;
   logic signed [3:0] as;
   logic [3:0]        bs;

   logic              in_ready_a, out_valid_a, ovf_a;
   logic signed [11:0] sum_as_a;
   logic [11:0]       sum_bs_a;
   logic              in_ready_b, out_valid_b, ovf_b;
   logic signed [5:0] sum_as_b;
   logic [5:0]        sum_bs_b;

   sub_accum #(.ACC_W(12), .BLOCK_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .as(as), .bs(bs), .out_valid(out_valid_a), .out_ready(out_ready),
      .sum_as(sum_as_a), .sum_bs(sum_bs_a), .ovf(ovf_a)
   );

   sub_accum #(.ACC_W(6), .BLOCK_LEN(BL)) dut_w6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .as(as), .bs(bs), .out_valid(out_valid_b), .out_ready(out_ready),
      .sum_as(sum_as_b), .sum_bs(sum_bs_b), .ovf(ovf_b)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference state: index 0 = 12-bit instance, 1 = 6-bit instance
   int m_as [2];
   int m_bs [2];
   bit m_ovf[2];
   int m_w  [2] = '{12, 6};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int add_s(input int acc, input int x, input int w, inout bit o);
      int r, lo, hi;
      r  = acc + x;
      lo = -(1 << (w - 1));
      hi = (1 << (w - 1)) - 1;
`ifdef SUB_ACCUM_SAT_EN
      if (r > hi) begin r = hi; o = 1'b1; end
      else if (r < lo) begin r = lo; o = 1'b1; end
`else
      if (r > hi) r -= (1 << w);
      else if (r < lo) r += (1 << w);
`endif
      return r;
   endfunction

   function automatic int add_u(input int acc, input int x, input int w, inout bit o);
      int r, hi;
      r  = acc + x;
      hi = (1 << w) - 1;
`ifdef SUB_ACCUM_SAT_EN
      if (r > hi) begin r = hi; o = 1'b1; end
`else
      if (r > hi) r -= (1 << w);
`endif
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_as[k] = 0; m_bs[k] = 0; m_ovf[k] = 1'b0;
      end
   endtask

   task automatic model_add(input int a, input int b);
      for (int k = 0; k < 2; k++) begin
         m_as[k] = add_s(m_as[k], a, m_w[k], m_ovf[k]);
         m_bs[k] = add_u(m_bs[k], b, m_w[k], m_ovf[k]);
      end
   endtask

   task automatic check_outputs(input string tag, input bit exp_valid);
      check({tag, ".valid12"}, 32'(out_valid_a), 32'(exp_valid));
      check({tag, ".ready12"}, 32'(in_ready_a),  32'(!exp_valid));
      check({tag, ".sum_as12"}, 32'(unsigned'(sum_as_a)), 32'(m_as[0]) & 32'hFFF);
      check({tag, ".sum_bs12"}, 32'(sum_bs_a), 32'(m_bs[0]) & 32'hFFF);
      check({tag, ".ovf12"},   32'(ovf_a), 32'(m_ovf[0]));
      check({tag, ".valid6"},  32'(out_valid_b), 32'(exp_valid));
      check({tag, ".ready6"},  32'(in_ready_b),  32'(!exp_valid));
      check({tag, ".sum_as6"}, 32'(unsigned'(sum_as_b)), 32'(m_as[1]) & 32'h3F);
      check({tag, ".sum_bs6"}, 32'(sum_bs_b), 32'(m_bs[1]) & 32'h3F);
      check({tag, ".ovf6"},    32'(ovf_b), 32'(m_ovf[1]));
   endtask

   // Called at a falling edge; returns at a falling edge with in_valid low.
   task automatic send(input int a, input int b, input int gap);
      repeat (gap) begin
         in_valid = 1'b0;
         as = 4'($urandom);
         bs = 4'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      as = 4'(a);
      bs = 4'(b);
      @(posedge clk);
      model_add(a, b);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_block(input string tag, input int av[BL], input int bv[BL],
                            input bit gaps, input int hold);
      for (int i = 0; i < BL; i++) begin
         send(av[i], bv[i], gaps ? int'($urandom_range(0, 2)) : 0);
         if (i == BL - 2) check({tag, ".early_valid"}, 32'(out_valid_a), 32'd0);
      end
      check_outputs({tag, ".result"}, 1'b1);
      repeat (hold) begin
         in_valid  = 1'b1;
         out_ready = 1'b0;
         as = 4'($urandom);
         bs = 4'($urandom);
         @(negedge clk);
         check_outputs({tag, ".hold"}, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      out_ready = 1'b0;
      check_outputs({tag, ".handoff"}, 1'b0);
   endtask

   task automatic do_reset(input string tag, input int cycles);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      repeat (cycles) @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      model_clear();
      check_outputs({tag, ".reset"}, 1'b0);
   endtask

   int av[BL];
   int bv[BL];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; as = '0; bs = '0;
      model_clear();
      @(negedge clk);
      do_reset("init", 2);

      for (int i = 0; i < BL; i++) begin av[i] = -1; bv[i] = 15; end
      run_block("ext", av, bv, 1'b0, 0);

      for (int i = 0; i < BL; i++) begin av[i] = -8; bv[i] = 0; end
      run_block("min", av, bv, 1'b0, 0);

      for (int i = 0; i < BL; i++) begin av[i] = 7; bv[i] = 15; end
      run_block("max", av, bv, 1'b0, 5);

      for (int i = 0; i < BL; i++) begin
         av[i] = int'($urandom_range(0, 15)) - 8;
         bv[i] = int'($urandom_range(0, 15));
      end
      run_block("rnd_contig", av, bv, 1'b0, 1);
      run_block("rnd_gaps", av, bv, 1'b1, 2);

      for (int i = 0; i < 3; i++) send(5, 9, 0);
      do_reset("mid2", 2);
      for (int i = 0; i < 3; i++) send(-3, 12, 0);
      do_reset("mid1", 1);
      for (int i = 0; i < BL; i++) begin av[i] = 1; bv[i] = 1; end
      run_block("ones", av, bv, 1'b0, 0);

      for (int i = 0; i < BL; i++) send(7, 15, 0);
      do_reset("in_hold", 1);

      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < BL; i++) begin
            av[i] = int'($urandom_range(0, 15)) - 8;
            bv[i] = int'($urandom_range(0, 15));
         end
         run_block("rand", av, bv, 1'b1, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
